// File: rtl/spu_cmd_sequencer.sv
// Byte-serial command front end for the SPU datapath: parses a header plus up to two
// operand bytes, issues one op with a timeout watchdog, and returns one response byte.
module spu_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [7:0]  ERR_TIMEOUT    = 8'hEE,
   parameter logic [7:0]  ERR_FORMAT     = 8'hEF
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_in_valid,
   input  logic [7:0] i_in_data,
   output logic       o_in_ready,
   output logic       o_op_start,
   output logic [3:0] o_op_code,
   output logic [7:0] o_op_a,
   output logic [7:0] o_op_b,
   input  logic       i_op_done,
   input  logic [7:0] i_op_result,
   output logic       o_out_valid,
   output logic [7:0] o_out_data,
   input  logic       i_out_ready,
   output logic       o_busy,
   output logic       o_err
);

   // state  | meaning
   // HDR    | waiting for header byte
   // ARG0   | waiting for operand A
   // ARG1   | waiting for operand B
   // ISSUE  | op_start pulse, watchdog cleared
   // WAIT   | waiting for op_done or timeout
   // RESP   | presenting response byte
   typedef enum logic [2:0] {
      S_HDR, S_ARG0, S_ARG1, S_ISSUE, S_WAIT, S_RESP
   } state_t;

   localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES - 1);

   state_t     r_state;
   logic [1:0] r_nargs;
   logic [7:0] r_cnt;
   logic       r_in_ready;
   logic       r_op_start;
   logic [3:0] r_op_code;
   logic [7:0] r_op_a;
   logic [7:0] r_op_b;
   logic       r_out_valid;
   logic [7:0] r_out_data;
   logic       r_busy;
   logic       r_err;

   logic w_in_xfer;
   logic w_out_xfer;
   logic w_unused_rsvd;

   assign w_in_xfer     = i_in_valid & r_in_ready;
   assign w_out_xfer    = r_out_valid & i_out_ready;
   assign w_unused_rsvd = &{1'b0, i_in_data[3:2]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_HDR;
         r_nargs     <= 2'd0;
         r_cnt       <= 8'd0;
         r_in_ready  <= 1'b1;
         r_op_start  <= 1'b0;
         r_op_code   <= 4'd0;
         r_op_a      <= 8'd0;
         r_op_b      <= 8'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= 8'd0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_op_start <= 1'b0;
         case (r_state)
            S_HDR: begin
               if (w_in_xfer) begin
                  r_op_code <= i_in_data[7:4];
                  r_nargs   <= i_in_data[1:0];
                  r_op_a    <= 8'd0;
                  r_op_b    <= 8'd0;
                  r_busy    <= 1'b1;
                  // CLRERR takes precedence over the operand count
                  if (i_in_data[7:4] == 4'hF) begin
                     r_err       <= 1'b0;
                     r_out_data  <= 8'h00;
                     r_out_valid <= 1'b1;
                     r_in_ready  <= 1'b0;
                     r_state     <= S_RESP;
                  end else if (i_in_data[1:0] == 2'd3) begin
                     r_err       <= 1'b1;
                     r_out_data  <= ERR_FORMAT;
                     r_out_valid <= 1'b1;
                     r_in_ready  <= 1'b0;
                     r_state     <= S_RESP;
                  end else if (i_in_data[1:0] == 2'd0) begin
                     r_op_start <= 1'b1;
                     r_in_ready <= 1'b0;
                     r_state    <= S_ISSUE;
                  end else begin
                     r_state <= S_ARG0;
                  end
               end
            end
            S_ARG0: begin
               if (w_in_xfer) begin
                  r_op_a <= i_in_data;
                  if (r_nargs == 2'd2) begin
                     r_state <= S_ARG1;
                  end else begin
                     r_op_start <= 1'b1;
                     r_in_ready <= 1'b0;
                     r_state    <= S_ISSUE;
                  end
               end
            end
            S_ARG1: begin
               if (w_in_xfer) begin
                  r_op_b     <= i_in_data;
                  r_op_start <= 1'b1;
                  r_in_ready <= 1'b0;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= 8'd0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // done is checked first so it wins on the limit cycle
               if (i_op_done) begin
                  r_out_data  <= i_op_result;
                  r_out_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else if (r_cnt == LP_LIMIT) begin
                  r_err       <= 1'b1;
                  r_out_data  <= ERR_TIMEOUT;
                  r_out_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RESP: begin
               if (w_out_xfer) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_HDR;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_HDR;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_op_start  = r_op_start;
   assign o_op_code   = r_op_code;
   assign o_op_a      = r_op_a;
   assign o_op_b      = r_op_b;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_busy      = r_busy;
   assign o_err       = r_err;

endmodule

// File: tb/tb_spu_cmd_sequencer.sv
// Directed bench for spu_cmd_sequencer: hand-computed frames covering normal ops,
// format/timeout errors, CLRERR, response back-pressure and reset during an op.
module tb_spu_cmd_sequencer;

   logic       i_clk;
   logic       i_rst;
   logic       i_in_valid;
   logic [7:0] i_in_data;
   logic       o_in_ready;
   logic       o_op_start;
   logic [3:0] o_op_code;
   logic [7:0] o_op_a;
   logic [7:0] o_op_b;
   logic       i_op_done;
   logic [7:0] i_op_result;
   logic       o_out_valid;
   logic [7:0] o_out_data;
   logic       i_out_ready;
   logic       o_busy;
   logic       o_err;

   int n_chk;
   int n_err;
   int n_start;
   int base;

   spu_cmd_sequencer #(
      .TIMEOUT_CYCLES(64),
      .ERR_TIMEOUT   (8'hEE),
      .ERR_FORMAT    (8'hEF)
   ) u_dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_in_valid (i_in_valid),
      .i_in_data  (i_in_data),
      .o_in_ready (o_in_ready),
      .o_op_start (o_op_start),
      .o_op_code  (o_op_code),
      .o_op_a     (o_op_a),
      .o_op_b     (o_op_b),
      .i_op_done  (i_op_done),
      .i_op_result(i_op_result),
      .o_out_valid(o_out_valid),
      .o_out_data (o_out_data),
      .i_out_ready(i_out_ready),
      .o_busy     (o_busy),
      .o_err      (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial n_start = 0;
   always @(posedge i_clk) if (o_op_start) n_start = n_start + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      i_in_valid = 1'b1;
      i_in_data  = d;
      for (int i = 0; i < 100 && !o_in_ready; i++) tick();
      chk("send_rdy", o_in_ready, 1'b1);
      tick();
      i_in_valid = 1'b0;
      i_in_data  = 8'h00;
   endtask

   // called in ISSUE: done pulses d cycles after the op_start cycle
   task automatic do_done(input int d, input logic [7:0] res);
      tick();
      chk("start_1cyc", o_op_start, 1'b0);
      repeat (d - 1) tick();
      i_op_done   = 1'b1;
      i_op_result = res;
      tick();
      i_op_done   = 1'b0;
      i_op_result = 8'h00;
      chk("done_lat", o_out_valid, 1'b1);
   endtask

   task automatic recv(input string tag, input logic [7:0] exp);
      for (int i = 0; i < 200 && !o_out_valid; i++) tick();
      chk({tag, "_vld"}, o_out_valid, 1'b1);
      chk({tag, "_dat"}, o_out_data, exp);
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
      chk({tag, "_drop"}, o_out_valid, 1'b0);
      chk({tag, "_rdy"}, o_in_ready, 1'b1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, o_in_ready, 1'b1);
      chk({tag, "_start"}, o_op_start, 1'b0);
      chk({tag, "_code"}, o_op_code, 4'h0);
      chk({tag, "_a"}, o_op_a, 8'h00);
      chk({tag, "_b"}, o_op_b, 8'h00);
      chk({tag, "_ovld"}, o_out_valid, 1'b0);
      chk({tag, "_odat"}, o_out_data, 8'h00);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_err"}, o_err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      n_chk       = 0;
      n_err       = 0;
      i_rst       = 1'b1;
      i_in_valid  = 1'b0;
      i_in_data   = 8'h00;
      i_op_done   = 1'b0;
      i_op_result = 8'h00;
      i_out_ready = 1'b0;
      repeat (3) tick();
      i_rst = 1'b0;
      chk_reset_vals("rst");

      // opcode 3, two operands, done 3 cycles after op_start
      base = n_start;
      send_byte(8'h32);
      chk("t1_busy", o_busy, 1'b1);
      send_byte(8'h11);
      send_byte(8'h22);
      chk("t1_start", o_op_start, 1'b1);
      chk("t1_code", o_op_code, 4'h3);
      chk("t1_a", o_op_a, 8'h11);
      chk("t1_b", o_op_b, 8'h22);
      do_done(3, 8'h33);
      chk("t1_code_hold", o_op_code, 4'h3);
      chk("t1_a_hold", o_op_a, 8'h11);
      chk("t1_err", o_err, 1'b0);
      chk("t1_nstart", n_start - base, 1);
      recv("t1", 8'h33);

      // one operand, immediate done
      send_byte(8'h21);
      send_byte(8'h44);
      chk("t2_start", o_op_start, 1'b1);
      chk("t2_code", o_op_code, 4'h2);
      chk("t2_a", o_op_a, 8'h44);
      chk("t2_b", o_op_b, 8'h00);
      do_done(1, 8'h55);
      recv("t2", 8'h55);

      // N=3 format error clears stale operands
      base = n_start;
      send_byte(8'h32);
      send_byte(8'h77);
      send_byte(8'h88);
      do_done(1, 8'h01);
      recv("t3pre", 8'h01);
      base = n_start;
      send_byte(8'h13);
      chk("fmt_vld", o_out_valid, 1'b1);
      chk("fmt_err", o_err, 1'b1);
      chk("fmt_a", o_op_a, 8'h00);
      chk("fmt_b", o_op_b, 8'h00);
      recv("fmt", 8'hEF);
      chk("fmt_nstart", n_start - base, 0);
      chk("fmt_err_sticky", o_err, 1'b1);

      // successful op does not clear err
      send_byte(8'h40);
      do_done(2, 8'h12);
      recv("sticky", 8'h12);
      chk("sticky_err", o_err, 1'b1);

      base = n_start;
      send_byte(8'hF0);
      chk("clr1_err", o_err, 1'b0);
      recv("clr1", 8'h00);
      chk("clr1_nstart", n_start - base, 0);

      // timeout after exactly 64 WAIT cycles
      send_byte(8'h50);
      chk("to_start", o_op_start, 1'b1);
      repeat (64) tick();
      chk("to_not_yet", o_out_valid, 1'b0);
      tick();
      chk("to_vld", o_out_valid, 1'b1);
      chk("to_err", o_err, 1'b1);
      recv("to", 8'hEE);

      base = n_start;
      send_byte(8'hF0);
      chk("clr2_err", o_err, 1'b0);
      recv("clr2", 8'h00);
      chk("clr2_nstart", n_start - base, 0);

      // done on the limit cycle wins
      send_byte(8'h60);
      repeat (64) tick();
      chk("lim_not_yet", o_out_valid, 1'b0);
      i_op_done   = 1'b1;
      i_op_result = 8'h7C;
      tick();
      i_op_done   = 1'b0;
      i_op_result = 8'h00;
      chk("lim_err", o_err, 1'b0);
      recv("lim", 8'h7C);

      // response back-pressure with a pending input byte
      send_byte(8'h40);
      do_done(1, 8'h5A);
      i_in_valid = 1'b1;
      i_in_data  = 8'hAA;
      for (int i = 0; i < 10; i++) begin
         chk("stall_rdy", o_in_ready, 1'b0);
         chk("stall_vld", o_out_valid, 1'b1);
         chk("stall_dat", o_out_data, 8'h5A);
         tick();
      end
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
      chk("stall_rel_rdy", o_in_ready, 1'b1);
      chk("stall_rel_vld", o_out_valid, 1'b0);
      tick();
      i_in_valid = 1'b0;
      i_in_data  = 8'h00;
      chk("aa_code", o_op_code, 4'hA);
      chk("aa_busy", o_busy, 1'b1);
      chk("aa_arg_rdy", o_in_ready, 1'b1);
      send_byte(8'h01);
      send_byte(8'h02);
      chk("aa_start", o_op_start, 1'b1);
      chk("aa_a", o_op_a, 8'h01);
      chk("aa_b", o_op_b, 8'h02);
      tick();

      // reset in WAIT, then a late done
      base  = n_start;
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk_reset_vals("wrst");
      i_op_done   = 1'b1;
      i_op_result = 8'h99;
      tick();
      i_op_done   = 1'b0;
      i_op_result = 8'h00;
      repeat (3) tick();
      chk_reset_vals("late");
      chk("late_nstart", n_start - base, 0);

      send_byte(8'h40);
      do_done(1, 8'h3C);
      recv("after", 8'h3C);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
